// File: rtl/countdown_timer.sv
// countdown_timer: programmable down counter with prescaled ticks, pause,
// abort and a terminal-count handshake (one-cycle tc_pulse plus a held
// expired flag that is cleared by ack).
//
// Optional build macro: COUNTDOWN_TIMER_AUTORELOAD_EN
//   When defined, the start value is kept in a reload register and the timer
//   reloads at terminal count instead of expiring; only abort or reset stop it.
//
// reset is asynchronous and active-low; its deassertion is synchronised
// outside this block.
`timescale 1ns/1ps

module countdown_timer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc_pulse,
    output logic             expired
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          tick;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload;
    logic             unused_ack;

    assign unused_ack = ack;
`endif

    // A count tick happens on the cycle the prescaler sits at its wrap value.
    always_comb begin
        tick = (presc == PMAX);
    end

    // Timer state machine; every output is a register updated here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            presc    <= '0;
            busy     <= 1'b0;
            tc_pulse <= 1'b0;
            expired  <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            reload   <= '0;
`endif
        end else begin
            tc_pulse <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                count   <= '0;
                presc   <= '0;
                busy    <= 1'b0;
                expired <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (load_val != '0) begin
                                count <= load_val;
                                presc <= '0;
                                busy  <= 1'b1;
                                state <= RUN;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                                reload <= load_val;
`endif
                            end
`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
                            else begin
                                count    <= '0;
                                tc_pulse <= 1'b1;
                                expired  <= 1'b1;
                                state    <= EXPIRED;
                            end
`endif
                        end
                    end

                    RUN: begin
                        presc <= tick ? '0 : presc + 1'b1;
                        // A tick on the same cycle as pause is handled before
                        // the pause takes effect.
                        if (tick && count == WIDTH'(1)) begin
                            tc_pulse <= 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                            count <= reload;
                            if (pause) begin
                                state <= PAUSE;
                            end
`else
                            count   <= '0;
                            busy    <= 1'b0;
                            expired <= 1'b1;
                            state   <= EXPIRED;
`endif
                        end else begin
                            if (tick) begin
                                count <= count - 1'b1;
                            end
                            if (pause) begin
                                state <= PAUSE;
                            end
                        end
                    end

                    PAUSE: begin
                        // Count and prescaler hold; resume picks up the held phase.
                        if (!pause) begin
                            state <= RUN;
                        end
                    end

                    EXPIRED: begin
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                        state <= IDLE;
`else
                        if (ack) begin
                            if (start && load_val != '0) begin
                                count   <= load_val;
                                presc   <= '0;
                                busy    <= 1'b1;
                                expired <= 1'b0;
                                state   <= RUN;
                            end else if (start) begin
                                tc_pulse <= 1'b1;
                            end else begin
                                expired <= 1'b0;
                                state   <= IDLE;
                            end
                        end
`endif
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed bench for countdown_timer with hand-computed
// expectations. Edge numbers in comments count from the edge that accepts start.
`timescale 1ns/1ps

module tb_countdown_timer;

    localparam int WIDTH = 4;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    localparam int PRESCALE = 1;
`else
    localparam int PRESCALE = 4;
`endif

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             abort;
    logic             ack;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc_pulse;
    logic             expired;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    countdown_timer #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .abort    (abort),
        .ack      (ack),
        .count    (count),
        .busy     (busy),
        .tc_pulse (tc_pulse),
        .expired  (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_idle(input string tag);
        check({tag, " count"},   32'(count), 0);
        check({tag, " busy"},    32'(busy), 0);
        check({tag, " tc"},      32'(tc_pulse), 0);
        check({tag, " expired"}, 32'(expired), 0);
    endtask

    logic tc_seen;

    initial begin
        reset    = 1'b0;
        load_val = '0;
        start    = 1'b0;
        pause    = 1'b0;
        abort    = 1'b0;
        ack      = 1'b0;
        #2;
        check_idle("reset");
        steps(2);
        reset = 1'b1;
        step();
        check_idle("post-reset");

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        // Auto-reload: load 2, PRESCALE 1 -> 2,1,2,1 with tc on each reload.
        load_val = 2; start = 1'b1; step(); start = 1'b0;
        check("ar e0 count", 32'(count), 2);
        check("ar e0 tc", 32'(tc_pulse), 0);
        step();
        check("ar e1 count", 32'(count), 1);
        check("ar e1 tc", 32'(tc_pulse), 0);
        ack = 1'b1; step(); ack = 1'b0;
        check("ar e2 count", 32'(count), 2);
        check("ar e2 tc", 32'(tc_pulse), 1);
        check("ar e2 expired", 32'(expired), 0);
        check("ar e2 busy", 32'(busy), 1);
        step();
        check("ar e3 count", 32'(count), 1);
        check("ar e3 tc", 32'(tc_pulse), 0);
        step();
        check("ar e4 count", 32'(count), 2);
        check("ar e4 tc", 32'(tc_pulse), 1);
        abort = 1'b1; step(); abort = 1'b0;
        check_idle("ar abort");
        steps(3);
        check_idle("ar stopped");
        load_val = 0; start = 1'b1; step(); start = 1'b0;
        check_idle("ar zero start");
`else
        // Basic run: load 3 -> 3 @e0, 2 @e4, 1 @e8, 0 @e12.
        load_val = 3; start = 1'b1; step(); start = 1'b0;   // e0
        check("t1 e0 count", 32'(count), 3);
        check("t1 e0 busy", 32'(busy), 1);
        steps(2);                                           // e2
        start = 1'b1; load_val = 7; step(); start = 1'b0;   // e3, start ignored
        check("t1 busy start ignored", 32'(count), 3);
        step();                                             // e4
        check("t1 e4 count", 32'(count), 2);
        steps(4);                                           // e8
        check("t1 e8 count", 32'(count), 1);
        steps(3);                                           // e11
        check("t1 e11 count", 32'(count), 1);
        check("t1 e11 tc", 32'(tc_pulse), 0);
        step();                                             // e12
        check("t1 e12 count", 32'(count), 0);
        check("t1 e12 tc", 32'(tc_pulse), 1);
        check("t1 e12 expired", 32'(expired), 1);
        check("t1 e12 busy", 32'(busy), 0);
        step();                                             // e13
        check("t1 e13 tc", 32'(tc_pulse), 0);
        check("t1 e13 expired", 32'(expired), 1);
        steps(2);
        check("t1 held expired", 32'(expired), 1);
        ack = 1'b1; step(); ack = 1'b0;
        check_idle("t1 ack");
        step();
        check_idle("t1 idle");

        // Pause sampled high on edges 6..10 -> terminal moves to e17.
        load_val = 3; start = 1'b1; step(); start = 1'b0;   // e0
        steps(5);                                           // e5
        pause = 1'b1; step();                               // e6
        check("t2 e6 count", 32'(count), 2);
        check("t2 e6 busy", 32'(busy), 1);
        steps(4);                                           // e10
        pause = 1'b0;
        check("t2 e10 count", 32'(count), 2);
        check("t2 e10 busy", 32'(busy), 1);
        step();                                             // e11
        check("t2 e11 count", 32'(count), 2);
        steps(2);                                           // e13
        check("t2 e13 count", 32'(count), 1);
        steps(3);                                           // e16
        check("t2 e16 count", 32'(count), 1);
        check("t2 e16 tc", 32'(tc_pulse), 0);
        check("t2 e16 busy", 32'(busy), 1);
        step();                                             // e17
        check("t2 e17 count", 32'(count), 0);
        check("t2 e17 tc", 32'(tc_pulse), 1);
        check("t2 e17 expired", 32'(expired), 1);
        ack = 1'b1; step(); ack = 1'b0;
        check_idle("t2 ack");

        // Abort at e7 of a load-9 run, then no terminal count ever appears.
        load_val = 9; start = 1'b1; step(); start = 1'b0;   // e0
        steps(6);                                           // e6
        check("t3 e6 count", 32'(count), 8);
        abort = 1'b1; step(); abort = 1'b0;                 // e7
        check_idle("t3 abort");
        tc_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            tc_seen = tc_seen | tc_pulse;
        end
        check("t3 no tc after abort", 32'(tc_seen), 0);
        load_val = 5; start = 1'b1; step(); start = 1'b0;   // e0
        check("t3 restart count", 32'(count), 5);
        check("t3 restart busy", 32'(busy), 1);

        // Asynchronous reset between edges while running at count 5.
        step();
        check("t5 pre-reset count", 32'(count), 5);
        #3 reset = 1'b0;
        #1;
        check_idle("t5 async reset");
        #2 reset = 1'b1;
        step();
        check_idle("t5 after reset");

        // Zero load expires immediately; start without ack is ignored.
        load_val = 0; start = 1'b1; step(); start = 1'b0;
        check("t4 tc", 32'(tc_pulse), 1);
        check("t4 expired", 32'(expired), 1);
        check("t4 count", 32'(count), 0);
        check("t4 busy", 32'(busy), 0);
        step();
        check("t4 tc drop", 32'(tc_pulse), 0);
        load_val = 4; start = 1'b1; step(); start = 1'b0;
        check("t4 start no ack expired", 32'(expired), 1);
        check("t4 start no ack count", 32'(count), 0);
        check("t4 start no ack busy", 32'(busy), 0);
        ack = 1'b1; start = 1'b1; load_val = 2; step(); ack = 1'b0; start = 1'b0;
        check("t4 restart count", 32'(count), 2);
        check("t4 restart busy", 32'(busy), 1);
        check("t4 restart expired", 32'(expired), 0);
        abort = 1'b1; step(); abort = 1'b0;
        check_idle("t4 abort");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
